// File: rtl/fifo_pkg.sv
// Shared definitions for the registered valid/ready transmit stage.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_sender.sv
// Producer-side transmit stage: a 2-entry skid buffer whose downstream-facing
// outputs all come from flops, sustaining one word per cycle across the link.
module fifo_skid_sender
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__data_in_valid,
    input  logic [DATA_WIDTH-1:0] i__data_in,
    output logic                  o__data_in_ready,
    output logic                  o__data_out_valid,
    output logic [DATA_WIDTH-1:0] o__data_out,
    input  logic                  i__data_out_ready,
    input  logic                  i__clear_all,
    output logic [1:0]            o__count
);

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  out_valid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    assign o__data_in_ready  = (state != FULL) & reset;
    assign in_fire           = i__data_in_valid & o__data_in_ready;
    assign out_fire          = out_valid_q & i__data_out_ready;
    assign o__data_out_valid = out_valid_q;
    assign o__data_out       = main_q;
    assign o__count          = state;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state   = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    next_state     = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Clear drops only the valid state; the data registers keep their contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (i__clear_all) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            out_valid_q <= (next_state != EMPTY);
            if (load_main_in) begin
                main_q <= i__data_in;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i__data_in;
            end
        end
    end

endmodule

// File: doc/fifo_skid_sender.md
Name: fifo_skid_sender

Overview:
- Registered transmit stage for the valid/ready FIFO interface used across the tile, including the first-word fall-through FIFOs.
- Sits on the producer side of a link: it accepts words from a local producer and drives a downstream FIFO input port.
- Every downstream-facing output comes straight from a flop, so no combinational path crosses the link.
- A 2-entry skid buffer holds full throughput (1 word/cycle) even though downstream ready is sampled only at the clock edge.

Parameters:
- DATA_WIDTH, 64, payload width in bits.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low: 0 = reset.
- i__data_in_valid  input  1  producer has a word this cycle.
- i__data_in  input  DATA_WIDTH  producer word.
- o__data_in_ready  output  1  sender accepts a producer word this cycle.
- o__data_out_valid  output  1  registered valid toward the downstream FIFO.
- o__data_out  output  DATA_WIDTH  registered word toward the downstream FIFO.
- i__data_out_ready  input  1  downstream accepts o__data_out this cycle.
- i__clear_all  input  1  synchronous flush of all held words.
- o__count  output  2  number of words held (0..2).

Behaviour:
- Fire rules:
  - in_fire = i__data_in_valid & o__data_in_ready.
  - out_fire = o__data_out_valid & i__data_out_ready.
- Storage: main register (drives o__data_out) and skid register.
- FSM states, with main and skid contents:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Output decode:
  - o__data_out_valid = 1 in BUSY/FULL; it is a flop, not decoded combinationally.
  - o__count = 0/1/2 for EMPTY/BUSY/FULL.
  - o__data_in_ready = (state != FULL) & reset. This is the only combinational output; it is forced 0 while reset = 0.
- Transitions, evaluated when reset = 1 and i__clear_all = 0:
  - EMPTY, in_fire: main <= i__data_in, go to BUSY.
  - BUSY, in_fire & out_fire: main <= i__data_in, stay in BUSY.
  - BUSY, in_fire & !out_fire: skid <= i__data_in, go to FULL.
  - BUSY, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main <= skid, go to BUSY. in_fire cannot occur in FULL.
  - Any other combination: hold state and data.
- Latency: a word accepted in cycle N appears on o__data_out in cycle N+1 at the earliest.
- Throughput: 1 word/cycle while downstream holds ready = 1.
- Ordering: strict FIFO order; a word is never dropped or duplicated except through a flush.
- Output stability: while o__data_out_valid = 1 and i__data_out_ready = 0, o__data_out must stay bit-stable.
- Reset: reset = 0 at an edge sets state EMPTY and clears main and skid to 0.
  - After that edge: o__data_out_valid = 0, o__data_out = 0, o__count = 0.
  - Reset mid-operation discards all held words.
- i__clear_all = 1 at an edge: go to EMPTY.
  - A concurrent producer word is dropped, even though o__data_in_ready was 1.
  - Data registers keep their values; only the valid state clears.
  - Reset has priority over clear_all.
- Downstream ready while o__data_out_valid = 0 is ignored.

Decomposition:
- Shared package (fifo_pkg): 2-bit enum typedef for the states (EMPTY = 0, BUSY = 1, FULL = 2) and a localparam for the skid depth (2).
- No sub-module is natural: the block is flat, two data registers plus a state register.

Test Plan:
- Reset and idle: hold reset = 0 for 3 cycles while driving valid = 1, data = 0xAA -> o__data_in_ready = 0, o__data_out_valid = 0, o__count = 0; after release, o__data_in_ready = 1.
- Streaming: downstream ready held 1, producer sends 1, 2, 3, 4 on consecutive cycles -> downstream sees 1, 2, 3, 4 on consecutive cycles, first word one cycle after its acceptance, o__count stays 1.
- Backpressure: downstream ready = 0, producer sends 0x10, 0x11, 0x12 -> only 0x10 and 0x11 accepted, o__count = 2, o__data_in_ready = 0, o__data_out holds 0x10 stable; set ready = 1 -> out 0x10, 0x11, then 0x12.
- FULL drain with refill: in FULL, ready = 1 for one cycle -> state BUSY, o__data_out = skid word, o__data_in_ready = 1 the same cycle.
- Clear: hold 2 words, assert i__clear_all with an input valid of 0x55 -> next cycle o__count = 0, o__data_out_valid = 0, and 0x55 never appears downstream.
- Reset mid-operation: in FULL, assert reset = 0 for 1 cycle -> o__data_out_valid = 0, o__data_out = 0, and neither held word is ever emitted afterwards.
